// File: rtl/fft_pkg.sv
// ============================================================================
// Module  : fft_pkg
// Brief   : Shared constants and types for the 512-point, 16-lane FFT front end.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package fft_pkg;

    localparam int LANES      = 16;
    localparam int SR_DEPTH   = 256;
    localparam int HALF_BEATS = 16;

    typedef logic [3:0] row_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        BFLY = 2'd2
    } step0_state_e;

endpackage

`default_nettype wire

// File: rtl/fft_beat_counter.sv
// ============================================================================
// Module  : fft_beat_counter
// Brief   : Beat counter with enable, synchronous clear and terminal-count flags.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module fft_beat_counter #(
    parameter int WIDTH = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             clr,
    output logic [WIDTH-1:0] count,
    output logic             tc,
    output logic             half_tc
);

    localparam logic [WIDTH-1:0] c_all_ones = '1;
    localparam logic [WIDTH-1:0] c_half_end = {1'b0, {(WIDTH-1){1'b1}}};

    logic [WIDTH-1:0] r_count;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            r_count <= '0;
        end else if (en) begin
            r_count <= r_count + WIDTH'(1);
        end
    end

    assign count   = r_count;
    assign tc      = (r_count == c_all_ones);
    assign half_tc = (r_count == c_half_end);

endmodule

`default_nettype wire

// File: rtl/fft_step0_seq.sv
// ============================================================================
// Module  : fft_step0_seq
// Brief   : Beat sequencer for the first radix-2 stage (fill, then butterfly).
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module fft_step0_seq
    import fft_pkg::*;
#(
    parameter int HALF_BEATS = 16,
    parameter int ROT_START  = 8,
    parameter int FCNT_W     = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              valid,
    input  logic              clear,
    output logic              sr_shift_en,
    output logic              bfly_en,
    output logic [3:0]        bfly_row,
    output logic              out_en,
    output logic [3:0]        out_row,
    output logic              out_rot,
    output logic              frame_start,
    output logic              frame_done,
    output logic              busy,
    output logic [FCNT_W-1:0] frame_cnt
);

    localparam logic [4:0] c_half = 5'(HALF_BEATS);
    localparam row_t       c_rot  = 4'(ROT_START);

    step0_state_e      r_state;
    logic              r_out_en;
    row_t              r_out_row;
    logic              r_out_rot;
    logic              r_frame_done;
    logic [FCNT_W-1:0] r_frame_cnt;

    logic       w_acc;
    logic [4:0] w_cnt;
    logic       w_tc;
    logic       w_half_tc;
    logic       w_bfly_en;
    row_t       w_bfly_row;
    logic       w_last;

    assign w_acc = valid & ~clear;

    fft_beat_counter #(
        .WIDTH (5)
    ) u_beat_cnt (
        .clk     (clk),
        .rst     (rst),
        .en      (w_acc),
        .clr     (clear),
        .count   (w_cnt),
        .tc      (w_tc),
        .half_tc (w_half_tc)
    );

    assign w_bfly_en  = w_acc & (r_state == BFLY);
    assign w_bfly_row = w_bfly_en ? row_t'(w_cnt - c_half) : '0;
    assign w_last     = w_bfly_en & w_tc;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= IDLE;
            r_out_en     <= 1'b0;
            r_out_row    <= '0;
            r_out_rot    <= 1'b0;
            r_frame_done <= 1'b0;
            r_frame_cnt  <= '0;
        end else if (clear) begin
            // Abort drops the frame but keeps the completed-frame tally.
            r_state      <= IDLE;
            r_out_en     <= 1'b0;
            r_out_row    <= '0;
            r_out_rot    <= 1'b0;
            r_frame_done <= 1'b0;
        end else begin
            case (r_state)
                IDLE:    if (w_acc)             r_state <= FILL;
                FILL:    if (w_acc && w_half_tc) r_state <= BFLY;
                BFLY:    if (w_last)            r_state <= IDLE;
                default:                        r_state <= IDLE;
            endcase

            r_out_en     <= w_bfly_en;
            r_frame_done <= w_last;
            if (w_bfly_en) begin
                r_out_row <= w_bfly_row;
                r_out_rot <= (w_bfly_row >= c_rot);
            end
            if (w_last) begin
                r_frame_cnt <= r_frame_cnt + FCNT_W'(1);
            end
        end
    end

    assign sr_shift_en = w_acc;
    assign bfly_en     = w_bfly_en;
    assign bfly_row    = w_bfly_row;
    assign frame_start = w_acc & (w_cnt == 5'd0);
    assign out_en      = r_out_en;
    assign out_row     = r_out_row;
    assign out_rot     = r_out_rot;
    assign frame_done  = r_frame_done;
    assign busy        = (r_state != IDLE);
    assign frame_cnt   = r_frame_cnt;

endmodule

`default_nettype wire
